// File: rtl/can_pkg.sv
// Shared definitions for the CAN receive-side form/CRC checker:
// receiver field codes, CRC-15 polynomial and form-flag bit positions.
package can_pkg;

  localparam logic [5:0] FF_ID_A       = 6'd0;
  localparam logic [5:0] FF_ID_B       = 6'd1;
  localparam logic [5:0] FF_DOUBT      = 6'd2;
  localparam logic [5:0] FF_EXT_RES    = 6'd3;
  localparam logic [5:0] FF_NORM_R0    = 6'd4;
  localparam logic [5:0] FF_EXT_RTR    = 6'd5;
  localparam logic [5:0] FF_DLC        = 6'd6;
  localparam logic [5:0] FF_DATA       = 6'd7;
  localparam logic [5:0] FF_CRC        = 6'd8;
  localparam logic [5:0] FF_CRC_DELIM  = 6'd9;
  localparam logic [5:0] FF_ACK_DELIM  = 6'd10;
  localparam logic [5:0] FF_ACK_SLOT   = 6'd11;
  localparam logic [5:0] FF_STUFF      = 6'd12;
  localparam logic [5:0] FF_CONCLUSION = 6'd13;
  localparam logic [5:0] FF_ERROR      = 6'd16;
  localparam logic [5:0] FF_RESET_VARS = 6'd19;
  localparam logic [5:0] FF_EOF        = 6'd20;
  localparam logic [5:0] FF_IDLE       = 6'd21;

  localparam logic [14:0] CRC15_POLY = 15'h4599;

  localparam int FM_SRR       = 0;
  localparam int FM_CRC_DELIM = 1;
  localparam int FM_ACK_DELIM = 2;
  localparam int FM_EOF       = 3;

  // Progress through the two "doubt" bits (SRR/RTR then IDE).
  typedef enum logic [1:0] {
    SRR_WAIT  = 2'd0,
    SRR_FIRST = 2'd1,
    SRR_DONE  = 2'd2
  } srr_phase_e;

  function automatic logic is_bit_event(input logic [5:0] field);
    return (field <= FF_ACK_SLOT) || (field == FF_EOF);
  endfunction

  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[14];
    return {crc[13:0], 1'b0} ^ (fb ? CRC15_POLY : 15'h0000);
  endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CRC-15 accumulator: one bit per bit_en strobe, cleared by reset or clear.
module can_crc15
  import can_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        bit_en,
  input  logic        bit_in,
  output logic [14:0] crc
);

  // NOTE: reset is synchronous here -- it is just the highest-priority branch
  // inside the clocked block, so rst_n is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (bit_en) begin
      crc <= crc15_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/can_form_crc_checker.sv
// Snoops the CAN receiver's field code and de-stuffed bit, raising sticky
// form-error and CRC-error flags that are cleared on reset or frame restart.
module can_form_crc_checker
  import can_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic [5:0] i_frame_field,
  input  logic       i_Data,
  output logic [3:0] o_form_monitor,
  output logic       o_CRC_monitor
);

  // Bit timing comes from the field code; the bit period is carried only so
  // existing instantiations keep elaborating.
  if (CLKS_PER_BIT < 1) begin : g_clks_per_bit_unused
  end

  logic        bit_event;
  logic        restart;
  logic        frozen;
  logic        checks_on;
  logic [14:0] crc;
  logic [14:0] rx_crc;
  logic [4:0]  rx_cnt;
  logic        srr_bit;
  srr_phase_e  srr_phase, srr_phase_nxt;
  logic [3:0]  form_set;
  logic        crc_set;

  assign bit_event = is_bit_event(i_frame_field);
  assign restart   = (i_frame_field == FF_RESET_VARS);
  assign checks_on = bit_event && !frozen;

  can_crc15 u_crc15 (
    .clk    (i_Clock),
    .rst_n  (i_Reset_n),
    .clear  (restart),
    .bit_en (bit_event && (i_frame_field <= FF_DATA)),
    .bit_in (i_Data),
    .crc    (crc)
  );

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n || restart) begin
      srr_phase <= SRR_WAIT;
    end else begin
      srr_phase <= srr_phase_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    srr_phase_nxt = srr_phase;
    form_set      = 4'b0000;
    crc_set       = 1'b0;

    if (bit_event && (i_frame_field == FF_DOUBT)) begin
      case (srr_phase)
        SRR_WAIT:  srr_phase_nxt = SRR_FIRST;
        SRR_FIRST: srr_phase_nxt = SRR_DONE;
        default:   srr_phase_nxt = SRR_DONE;
      endcase
    end

    if (checks_on) begin
      case (i_frame_field)
        FF_DOUBT: begin
          // Recessive IDE after a dominant SRR is illegal in either frame format.
          if (srr_phase == SRR_FIRST && i_Data && !srr_bit) form_set[FM_SRR] = 1'b1;
        end
        FF_CRC_DELIM: begin
          form_set[FM_CRC_DELIM] = !i_Data;
          crc_set = (rx_crc != crc) || (rx_cnt != 5'd15);
        end
        FF_ACK_DELIM: form_set[FM_ACK_DELIM] = !i_Data;
        FF_EOF:       form_set[FM_EOF]       = !i_Data;
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n || restart) begin
      frozen         <= 1'b0;
      o_form_monitor <= 4'b0000;
      o_CRC_monitor  <= 1'b0;
      rx_crc         <= '0;
      rx_cnt         <= '0;
      srr_bit        <= 1'b0;
    end else begin
      if (i_frame_field == FF_ERROR) frozen <= 1'b1;
      o_form_monitor <= o_form_monitor | form_set;
      o_CRC_monitor  <= o_CRC_monitor | crc_set;
      if (bit_event && i_frame_field == FF_DOUBT && srr_phase == SRR_WAIT) begin
        srr_bit <= i_Data;
      end
      if (bit_event && i_frame_field == FF_CRC) begin
        rx_crc <= {rx_crc[13:0], i_Data};
        if (rx_cnt != 5'd16) rx_cnt <= rx_cnt + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_can_form_crc_checker.sv
// Directed-vector bench: stimulus pushes expected flags into a queue, a
// monitor pops and compares on every checked bit's output update.
module tb_can_form_crc_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] field = 6'd12;
  logic       data = 1'b1;
  logic [3:0] form_mon;
  logic       crc_mon;

  typedef struct {
    string      name;
    logic [3:0] form;
    logic       crc;
  } exp_t;

  exp_t        exp_q[$];
  logic        chk_strobe = 1'b0;
  logic [14:0] m_crc = '0;
  int          n_vec = 0;
  int          n_err = 0;

  can_form_crc_checker #(.CLKS_PER_BIT(10)) dut (
    .i_Clock        (clk),
    .i_Reset_n      (rst_n),
    .i_frame_field  (field),
    .i_Data         (data),
    .o_form_monitor (form_mon),
    .o_CRC_monitor  (crc_mon)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] model_crc(input logic [14:0] c, input logic b);
    logic [14:0] n;
    n = {c[13:0], 1'b0};
    if (b ^ c[14]) n = n ^ 15'h4599;
    return n;
  endfunction

  // Monitor: the DUT's registered outputs for a strobed bit are sampled 1ns after its edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (chk_strobe) begin
        #1;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL %s: no expectation queued", "scoreboard");
        end else begin
          e = exp_q.pop_front();
          if (form_mon !== e.form || crc_mon !== e.crc) begin
            n_err++;
            $display("FAIL %s: form=%b crc=%b, required form=%b crc=%b",
                     e.name, form_mon, crc_mon, e.form, e.crc);
          end
        end
      end
    end
  end

  task automatic step(input logic [5:0] f, input logic d, input bit chk = 0,
                      input logic [3:0] ef = 4'b0, input logic ec = 1'b0,
                      input string nm = "");
    @(negedge clk);
    field = f;
    data = d;
    chk_strobe = chk;
    if (chk) exp_q.push_back('{nm, ef, ec});
    if (f == 6'd19) m_crc = '0;
    else if (f <= 6'd7) m_crc = model_crc(m_crc, d);
    @(negedge clk);
    field = 6'd12;
    data = 1'b1;
    chk_strobe = 1'b0;
  endtask

  task automatic send(input logic [5:0] f, input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) step(f, val[i]);
  endtask

  task automatic expect_now(input logic [3:0] ef, input logic ec, input string nm);
    step(6'd12, 1'b1, 1, ef, ec, nm);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n = 1'b0;
    field = 6'd12;
    @(negedge clk);
    chk_strobe = 1'b1;
    exp_q.push_back('{nm, 4'b0000, 1'b0});
    @(negedge clk);
    chk_strobe = 1'b0;
    rst_n = 1'b1;
    m_crc = '0;
  endtask

  // Standard remote frame header: ID=0, RTR=1, IDE=0, r0=0, DLC=0.
  task automatic std_remote_hdr();
    step(6'd19, 1'b1);
    send(6'd0, 32'd0, 11);
    step(6'd2, 1'b1);
    step(6'd2, 1'b0, 1, 4'b0000, 1'b0, "remote_doubt");
    step(6'd4, 1'b0);
    send(6'd6, 32'd0, 4);
  endtask

  // Standard data frame header, everything dominant, DLC=0.
  task automatic std_zero_hdr();
    step(6'd19, 1'b1);
    send(6'd0, 32'd0, 11);
    step(6'd2, 1'b0);
    step(6'd2, 1'b0);
    step(6'd4, 1'b0);
    send(6'd6, 32'd0, 4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset, then reset again mid-frame with a flag already set.
    do_reset("reset_initial");
    step(6'd19, 1'b1);
    send(6'd0, 32'd0, 11);
    step(6'd2, 1'b0);
    step(6'd2, 1'b1, 1, 4'b0001, 1'b0, "srr_latency");
    send(6'd1, 32'd0, 5);
    do_reset("reset_midframe");
    expect_now(4'b0000, 1'b0, "reset_hold");

    // Valid standard remote frame, CRC 0x73C5.
    std_remote_hdr();
    send(6'd8, 32'h73C5, 15);
    step(6'd9, 1'b1, 1, 4'b0000, 1'b0, "remote_crc_ok");
    step(6'd11, 1'b0);
    step(6'd10, 1'b1, 1, 4'b0000, 1'b0, "remote_ack_delim");
    send(6'd20, 32'h7F, 7);
    expect_now(4'b0000, 1'b0, "remote_eof");

    // Same frame with the last CRC bit inverted.
    std_remote_hdr();
    send(6'd8, 32'h73C4, 15);
    step(6'd9, 1'b1, 1, 4'b0000, 1'b1, "bad_crc");
    step(6'd11, 1'b0);
    step(6'd10, 1'b1);
    send(6'd20, 32'h7F, 7);
    expect_now(4'b0000, 1'b1, "bad_crc_sticky");

    // All-dominant data frame with dominant CRC and ACK delimiters.
    std_zero_hdr();
    send(6'd8, 32'd0, 15);
    step(6'd9, 1'b0, 1, 4'b0010, 1'b0, "crc_delim_err");
    step(6'd11, 1'b0);
    step(6'd10, 1'b0, 1, 4'b0110, 1'b0, "ack_delim_err");
    send(6'd20, 32'h7F, 7);
    expect_now(4'b0110, 1'b0, "delim_errs_sticky");

    // Extended frame: SRR dominant with IDE recessive, 4th EOF bit dominant.
    step(6'd19, 1'b1);
    send(6'd0, 32'h123, 11);
    step(6'd2, 1'b0);
    step(6'd2, 1'b1, 1, 4'b0001, 1'b0, "ext_srr_err");
    send(6'd1, 32'h2A5A5, 18);
    step(6'd5, 1'b0);
    send(6'd3, 32'd0, 2);
    send(6'd6, 32'd1, 4);
    send(6'd7, 32'hA5, 8);
    send(6'd8, {17'd0, m_crc}, 15);
    step(6'd9, 1'b1, 1, 4'b0001, 1'b0, "ext_crc_ok");
    step(6'd11, 1'b0);
    step(6'd10, 1'b1);
    send(6'd20, 32'h7, 3);
    step(6'd20, 1'b0, 1, 4'b1001, 1'b0, "eof_err");
    send(6'd20, 32'h7, 3);
    expect_now(4'b1001, 1'b0, "eof_err_sticky");
    step(6'd19, 1'b1);
    expect_now(4'b0000, 1'b0, "restart_clears");

    // Short CRC field, then error frame freezes further checks.
    std_zero_hdr();
    send(6'd8, 32'd0, 14);
    step(6'd9, 1'b1, 1, 4'b0000, 1'b1, "crc_count14");
    step(6'd16, 1'b1);
    step(6'd9, 1'b0, 1, 4'b0000, 1'b1, "frozen_crc_delim");
    step(6'd10, 1'b0, 1, 4'b0000, 1'b1, "frozen_ack_delim");
    step(6'd20, 1'b0, 1, 4'b0000, 1'b1, "frozen_eof");
    step(6'd19, 1'b1);
    expect_now(4'b0000, 1'b0, "unfreeze_clear");

    // Third doubt bit ignored; checks live again after restart; EOF past 7 bits.
    step(6'd2, 1'b0);
    step(6'd2, 1'b0);
    step(6'd2, 1'b1, 1, 4'b0000, 1'b0, "third_doubt_ignored");
    step(6'd9, 1'b0, 1, 4'b0010, 1'b1, "no_crc_bits");
    send(6'd20, 32'hFF, 8);
    step(6'd20, 1'b0, 1, 4'b1010, 1'b1, "eof_bit9");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
